// File: rtl/transceiver_pkg.sv
// Shared constants for the serializer/deserializer pair: default width, bit order and counter sizing.
package transceiver_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam bit MSB_FIRST_C = 1'b1;
  localparam bit LSB_FIRST_C = 1'b0;

  // Bit-counter width for a word of w bits; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/deserializer_sipo_if.sv
// Serial-in / parallel-out bus: serial strobes plus the valid/ready word output.
interface deserializer_sipo_if
  import transceiver_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
);
  logic                  shift;
  logic                  srl_in;
  logic                  sync;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid;
  logic                  busy;
  logic                  overrun;

  modport master (
    input  shift, srl_in, sync, ready,
    output data_out, valid, busy, overrun
  );

  modport slave (
    output shift, srl_in, sync, ready,
    input  data_out, valid, busy, overrun
  );
endinterface

// File: rtl/sipo_out_buf.sv
// One-entry valid/ready holding register; flags a completed word that finds the buffer still full.
module sipo_out_buf #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  complete,
  input  logic [DATA_WIDTH-1:0] word,
  input  logic                  ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  output logic                  overrun
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_e;

  buf_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  overrun_q, overrun_d;

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    overrun_d = 1'b0;
    case (state_q)
      EMPTY: begin
        if (complete) begin
          data_d  = word;
          state_d = FULL;
        end
      end
      FULL: begin
        if (ready) begin
          if (complete) data_d = word;
          else          state_d = EMPTY;
        end else if (complete) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_out = data_q;
  assign valid    = (state_q == FULL);
  assign overrun  = overrun_q;

endmodule

// File: rtl/deserializer_sipo.sv
// SIPO deserializer: shifts srl_in on each strobe, aligns on sync, hands full words to sipo_out_buf.
module deserializer_sipo
  import transceiver_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter bit          MSB_FIRST  = MSB_FIRST_C
) (
  input  logic                clk,
  input  logic                rst,
  deserializer_sipo_if.master bus
);

  localparam int unsigned CNT_W = cnt_w(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] shifted_c;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  complete_c;
  logic [DATA_WIDTH-1:0] data_out_w;
  logic                  valid_w;
  logic                  overrun_w;

  always_comb begin
    if (MSB_FIRST) shifted_c = {shreg_q[DATA_WIDTH-2:0], bus.srl_in};
    else           shifted_c = {bus.srl_in, shreg_q[DATA_WIDTH-1:1]};

    complete_c = bus.shift && !bus.sync && (cnt_q == CNT_LAST);
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;

    // A sync strobe restarts the word; with shift it also carries bit 0 of the new word.
    if (bus.sync) begin
      if (bus.shift) begin
        cnt_d = CNT_W'(1);
        if (MSB_FIRST) shreg_d = {{(DATA_WIDTH-1){1'b0}}, bus.srl_in};
        else           shreg_d = {bus.srl_in, {(DATA_WIDTH-1){1'b0}}};
      end else begin
        cnt_d   = '0;
        shreg_d = '0;
      end
    end else if (bus.shift) begin
      shreg_d = shifted_c;
      cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end

    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  sipo_out_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_buf (
    .clk      (clk),
    .rst      (rst),
    .complete (complete_c),
    .word     (shifted_c),
    .ready    (bus.ready),
    .data_out (data_out_w),
    .valid    (valid_w),
    .overrun  (overrun_w)
  );

  assign bus.data_out = data_out_w;
  assign bus.valid    = valid_w;
  assign bus.overrun  = overrun_w;
  assign bus.busy     = busy_q;

endmodule
